// File: rtl/mips_cpu_bus_if.sv
// Avalon-MM master bridging the CPU control FSM to memory for fetches and data accesses.
// One request is in flight at a time. Bus outputs are registered and held through
// avm_waitrequest. Load data is lane-extracted and sign- or zero-extended.
// Optional stall timeout: define MIPS_BUS_TIMEOUT_EN to abort accesses that stall for
// TIMEOUT_CYCLES cycles. Without it the master waits indefinitely and err_timeout is 0.
module mips_cpu_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misaligned,
    output logic        err_timeout,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e      state_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        signed_q;
    logic        avm_read_q;
    logic        avm_write_q;
    logic [31:0] avm_address_q;
    logic [31:0] avm_writedata_q;
    logic [3:0]  avm_byteenable_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        misaligned_q;

    logic        req_legal;
    logic [3:0]  req_be;
    logic [31:0] req_lanes;
    logic [31:0] lane_data;
    logic [31:0] load_data;
    logic        timeout_hit;

    if (TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    // Legality check and byte-lane steering of the live request
    always_comb begin
        req_legal = 1'b1;
        req_be    = 4'b1111;
        req_lanes = req_wdata;
        unique case (req_size)
            2'b00: begin
                req_be    = 4'b0001 << req_addr[1:0];
                req_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_legal = ~req_addr[0];
                req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                req_lanes = {2{req_wdata[15:0]}};
            end
            2'b10: req_legal = (req_addr[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    // Pull the addressed lane down to bit 0 and extend it to 32 bits
    always_comb begin
        lane_data = avm_readdata >> {lane_q, 3'b000};
        unique case (size_q)
            2'b00:   load_data = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_data = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
            default: load_data = lane_data;
        endcase
    end

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] stall_cnt_q;
    logic            err_timeout_q;

    // Abort on the stall edge that completes TIMEOUT_CYCLES stalled cycles
    assign timeout_hit = avm_waitrequest && (32'(stall_cnt_q) == TIMEOUT_CYCLES - 1);

    // Stall counter, cleared whenever the master is outside BUS
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= (state_q == StBus) && timeout_hit;
            if (state_q != StBus) begin
                stall_cnt_q <= '0;
            end else if (avm_waitrequest) begin
                stall_cnt_q <= stall_cnt_q + CntW'(1);
            end
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Request FSM with registered bus and response outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            size_q           <= 2'b00;
            lane_q           <= 2'b00;
            signed_q         <= 1'b0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_address_q    <= '0;
            avm_writedata_q  <= '0;
            avm_byteenable_q <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            misaligned_q     <= 1'b0;
        end else begin
            rsp_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (req_legal) begin
                            avm_address_q    <= {req_addr[31:2], 2'b00};
                            avm_read_q       <= ~req_write;
                            avm_write_q      <= req_write;
                            avm_byteenable_q <= req_be;
                            avm_writedata_q  <= req_lanes;
                            size_q           <= req_size;
                            lane_q           <= req_addr[1:0];
                            signed_q         <= req_signed;
                            state_q          <= StBus;
                        end else begin
                            misaligned_q <= 1'b1;
                        end
                    end
                end
                StBus: begin
                    if (timeout_hit) begin
                        avm_read_q  <= 1'b0;
                        avm_write_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= StIdle;
                    end else if (!avm_waitrequest) begin
                        avm_read_q  <= 1'b0;
                        avm_write_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        // Stores return zero; readdata is meaningless for them
                        rsp_rdata_q <= avm_write_q ? '0 : load_data;
                        state_q     <= StResp;
                    end
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready      = (state_q == StIdle);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign misaligned     = misaligned_q;
    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;

endmodule

// File: tb/tb_mips_cpu_bus_if.sv
// Self-checking bench for mips_cpu_bus_if: expected load results are queued at request
// time and compared when rsp_valid pulses.
module tb_mips_cpu_bus_if;

    localparam int unsigned TimeoutCycles = 8;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misaligned;
    logic        err_timeout;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int          n_pass;
    int          n_total;
    logic [31:0] sb_q[$];

    mips_cpu_bus_if #(
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .misaligned     (misaligned),
        .err_timeout    (err_timeout),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic test_reset();
        reset_n         = 1'b0;
        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_addr        = '0;
        req_size        = 2'b00;
        req_signed      = 1'b0;
        req_wdata       = '0;
        avm_readdata    = '0;
        avm_waitrequest = 1'b0;
        #1;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready);
        else n_pass++;
        n_total++;
        if ({avm_read, avm_write, avm_byteenable, rsp_valid, misaligned, err_timeout} !== 9'd0)
            $display("FAIL reset_ctrl: got %b want 0", {avm_read, avm_write, avm_byteenable,
                                                        rsp_valid, misaligned, err_timeout});
        else n_pass++;
        n_total++;
        if ({avm_address, avm_writedata, rsp_rdata} !== 96'd0)
            $display("FAIL reset_data: got %h want 0", {avm_address, avm_writedata, rsp_rdata});
        else n_pass++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One access with `waits` stall cycles; starts and ends on a negedge.
    task automatic do_access(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int waits, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rsp);
        int          bus_cycles;
        int          rsp_cycle;
        int          rsp_count;
        logic [31:0] exp;
        bus_cycles = 0;
        rsp_cycle  = 0;
        rsp_count  = 0;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", tag, req_ready);
        else n_pass++;
        req_valid       = 1'b1;
        req_write       = wr;
        req_addr        = addr;
        req_size        = size;
        req_signed      = sgn;
        req_wdata       = wdata;
        avm_waitrequest = (waits > 0);
        avm_readdata    = ~rdata;
        sb_q.push_back(exp_rsp);
        @(posedge clk);
        #1;
        // Scramble request inputs so the bus must come from latched state
        req_valid  = 1'b0;
        req_addr   = ~addr;
        req_wdata  = ~wdata;
        req_size   = 2'b11;
        req_signed = ~sgn;
        for (int cyc = 1; cyc <= waits + 4; cyc++) begin
            @(negedge clk);
            if (avm_read || avm_write) begin
                bus_cycles++;
                n_total++;
                if ({avm_address, avm_byteenable, avm_read, avm_write} !==
                    {addr & 32'hFFFF_FFFC, exp_be, ~wr, wr})
                    $display("FAIL %s_bus c%0d: got a=%h be=%b r=%b w=%b want a=%h be=%b r=%b w=%b",
                             tag, cyc, avm_address, avm_byteenable, avm_read, avm_write,
                             addr & 32'hFFFF_FFFC, exp_be, ~wr, wr);
                else n_pass++;
                if (wr) begin
                    n_total++;
                    if (avm_writedata !== exp_wdata)
                        $display("FAIL %s_wdata c%0d: got %h want %h", tag, cyc, avm_writedata,
                                 exp_wdata);
                    else n_pass++;
                end
            end
            if (rsp_valid) begin
                rsp_count++;
                rsp_cycle = cyc;
                n_total++;
                if (sb_q.size() == 0) begin
                    $display("FAIL %s_rsp_extra: got rsp_valid want none", tag);
                end else begin
                    exp = sb_q.pop_front();
                    if (rsp_rdata !== exp)
                        $display("FAIL %s_rdata: got %h want %h", tag, rsp_rdata, exp);
                    else n_pass++;
                end
                n_total++;
                if (err_timeout !== 1'b0) $display("FAIL %s_err: got %b want 0", tag, err_timeout);
                else n_pass++;
            end
            avm_waitrequest = (cyc <= waits);
            avm_readdata    = (cyc <= waits) ? ~rdata : rdata;
        end
        n_total++;
        if (bus_cycles !== waits + 1)
            $display("FAIL %s_bus_len: got %0d want %0d", tag, bus_cycles, waits + 1);
        else n_pass++;
        n_total++;
        if (rsp_count !== 1 || rsp_cycle !== waits + 2)
            $display("FAIL %s_latency: got %0d pulses at c%0d want 1 at c%0d", tag, rsp_count,
                     rsp_cycle, waits + 2);
        else n_pass++;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL %s_ready_after: got %b want 1", tag, req_ready);
        else n_pass++;
        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL %s_rsp_missing: got %0d pending want 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_word_load();
        do_access("word_ld", 1'b0, 32'h1000_0004, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 0,
                  4'b1111, 32'h0, 32'hDEAD_BEEF);
        do_access("word_ld_w2", 1'b0, 32'h1000_0008, 2'b10, 1'b1, 32'h0, 32'h8000_0001, 2,
                  4'b1111, 32'h0, 32'h8000_0001);
    endtask

    task automatic test_sub_word_load();
        do_access("byte_s", 1'b0, 32'h1000_0003, 2'b00, 1'b1, 32'h0, 32'h8012_3456, 0,
                  4'b1000, 32'h0, 32'hFFFF_FF80);
        do_access("byte_u", 1'b0, 32'h1000_0003, 2'b00, 1'b0, 32'h0, 32'h8012_3456, 0,
                  4'b1000, 32'h0, 32'h0000_0080);
        do_access("byte1_s", 1'b0, 32'h1000_0001, 2'b00, 1'b1, 32'h0, 32'hDEAD_BEEF, 1,
                  4'b0010, 32'h0, 32'hFFFF_FFBE);
        do_access("half_hi_s", 1'b0, 32'h1000_0002, 2'b01, 1'b1, 32'h0, 32'h8012_3456, 0,
                  4'b1100, 32'h0, 32'hFFFF_8012);
        do_access("half_lo_u", 1'b0, 32'h1000_0000, 2'b01, 1'b0, 32'h0, 32'h8012_F456, 0,
                  4'b0011, 32'h0, 32'h0000_F456);
    endtask

    task automatic test_store();
        do_access("half_st", 1'b1, 32'h1000_0002, 2'b01, 1'b0, 32'h0000_ABCD, 32'h1234_5678, 3,
                  4'b1100, 32'hABCD_ABCD, 32'h0);
        do_access("byte_st", 1'b1, 32'h1000_0001, 2'b00, 1'b0, 32'h0000_00A5, 32'hFFFF_FFFF, 0,
                  4'b0010, 32'hA5A5_A5A5, 32'h0);
        do_access("word_st", 1'b1, 32'h2000_0010, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h1111_1111, 1,
                  4'b1111, 32'hCAFE_F00D, 32'h0);
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs[4];
        logic [1:0]  sizes[4];
        addrs = '{32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 32'h1000_0000};
        sizes = '{2'b10, 2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 4; i++) begin
            req_valid  = 1'b1;
            req_write  = 1'b0;
            req_addr   = addrs[i];
            req_size   = sizes[i];
            req_signed = 1'b0;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            for (int cyc = 1; cyc <= 3; cyc++) begin
                @(negedge clk);
                n_total++;
                if ({misaligned, avm_read, avm_write, rsp_valid, req_ready} !==
                    {cyc == 1, 1'b0, 1'b0, 1'b0, 1'b1})
                    $display("FAIL misalign%0d c%0d: got mis/rd/wr/rsp/rdy=%b want %b", i, cyc,
                             {misaligned, avm_read, avm_write, rsp_valid, req_ready},
                             {cyc == 1, 4'b0001});
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_bus();
        req_valid       = 1'b1;
        req_write       = 1'b0;
        req_addr        = 32'h1000_0008;
        req_size        = 2'b10;
        avm_waitrequest = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({avm_read, req_ready} !== 2'b10)
            $display("FAIL rst_bus_pre: got rd/rdy=%b want 10", {avm_read, req_ready});
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({avm_read, avm_write, req_ready} !== 3'b001)
            $display("FAIL rst_bus_async: got rd/wr/rdy=%b want 001",
                     {avm_read, avm_write, req_ready});
        else n_pass++;
        @(negedge clk);
        reset_n         = 1'b1;
        avm_waitrequest = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            n_total++;
            if ({rsp_valid, avm_read, req_ready} !== 3'b001)
                $display("FAIL rst_bus_after c%0d: got rsp/rd/rdy=%b want 001", cyc,
                         {rsp_valid, avm_read, req_ready});
            else n_pass++;
        end
    endtask

    // Second request is held while the first is in flight and must wait for IDLE.
    task automatic test_back_to_back();
        int          rsp_count;
        logic [31:0] exp;
        rsp_count       = 0;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h1122_3344;
        req_valid       = 1'b1;
        req_write       = 1'b0;
        req_addr        = 32'h2000_0000;
        req_size        = 2'b10;
        req_signed      = 1'b0;
        sb_q.push_back(32'h1122_3344);
        sb_q.push_back(32'h0000_0022);
        @(posedge clk);
        #1;
        req_addr = 32'h2000_0002;
        req_size = 2'b00;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (cyc == 1 || cyc == 3) begin
                n_total++;
                if (req_ready !== (cyc == 3))
                    $display("FAIL b2b_ready c%0d: got %b want %b", cyc, req_ready, cyc == 3);
                else n_pass++;
            end
            if (rsp_valid) begin
                rsp_count++;
                n_total++;
                if (sb_q.size() == 0) begin
                    $display("FAIL b2b_rsp_extra c%0d: got rsp_valid want none", cyc);
                end else begin
                    exp = sb_q.pop_front();
                    if (rsp_rdata !== exp)
                        $display("FAIL b2b_rdata c%0d: got %h want %h", cyc, rsp_rdata, exp);
                    else n_pass++;
                end
            end
            if (cyc == 3) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        n_total++;
        if (rsp_count !== 2) $display("FAIL b2b_count: got %0d want 2", rsp_count);
        else n_pass++;
        sb_q.delete();
    endtask

`ifdef MIPS_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int read_cycles;
        int hit_cycle;
        read_cycles     = 0;
        hit_cycle       = 0;
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'hFFFF_FFFF;
        req_valid       = 1'b1;
        req_write       = 1'b0;
        req_addr        = 32'h3000_0000;
        req_size        = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= TimeoutCycles + 4; cyc++) begin
            @(negedge clk);
            if (avm_read) read_cycles++;
            if (rsp_valid || err_timeout) begin
                hit_cycle = cyc;
                n_total++;
                if ({rsp_valid, err_timeout, rsp_rdata} !== {2'b11, 32'h0})
                    $display("FAIL timeout_rsp: got v/e=%b%b rdata=%h want 11 0", rsp_valid,
                             err_timeout, rsp_rdata);
                else n_pass++;
            end
        end
        n_total++;
        if (hit_cycle !== TimeoutCycles + 1 || read_cycles !== TimeoutCycles)
            $display("FAIL timeout_when: got c%0d rd=%0d want c%0d rd=%0d", hit_cycle,
                     read_cycles, TimeoutCycles + 1, TimeoutCycles);
        else n_pass++;
        avm_waitrequest = 1'b0;
        do_access("after_to", 1'b0, 32'h3000_0004, 2'b10, 1'b0, 32'h0, 32'h0BAD_F00D, 0,
                  4'b1111, 32'h0, 32'h0BAD_F00D);
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_word_load();
        test_sub_word_load();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_bus();
`ifdef MIPS_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
